// File: rtl/fpu_pkg.sv
// Shared definitions for the sequenced FPU operators: FSM encoding,
// IEEE-754 single-precision constants and small exponent helpers.
package fpu_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        PREP     = 4'd1,
        DIV_REQ  = 4'd2,
        DIV_WAIT = 4'd3,
        ADD_REQ  = 4'd4,
        ADD_WAIT = 4'd5,
        HALVE    = 4'd6,
        PACK     = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic [31:0] QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] PINF     = 32'h7F80_0000;
    localparam logic [7:0]  EXP_BIAS = 8'd127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    // Divide a positive normal float by two by decrementing its exponent.
    function automatic logic [31:0] fp_halve(input logic [31:0] v);
        return {v[31], v[30:23] - 8'd1, v[22:0]};
    endfunction

    // Rescale a normal float by 2^de (8-bit modular exponent add), sign forced positive.
    function automatic logic [31:0] fp_scale(input logic [31:0] v, input logic [7:0] de);
        return {1'b0, v[30:23] + de, v[22:0]};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational single-precision operand classifier. Denormals report as
// zero because the sequenced operators flush them.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] x,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan,
    output logic        is_snan,
    output logic        is_neg
);

    logic       exp_max_s;
    logic       man_zero_s;

    assign exp_max_s  = (x[30:23] == EXP_MAX);
    assign man_zero_s = (x[22:0] == 23'd0);

    assign is_zero = (x[30:23] == 8'd0);
    assign is_inf  = exp_max_s && man_zero_s;
    assign is_nan  = exp_max_s && !man_zero_s;
    assign is_snan = is_nan && !x[22];
    assign is_neg  = x[31];

endmodule

// File: rtl/fsqrt_nr_sequencer.sv
// Multi-cycle single-precision square root by Newton-Raphson on the
// mantissa, x <- (x + m/x)/2, using a shared external divider and adder
// through start/done handshakes.
module fsqrt_nr_sequencer
    import fpu_pkg::*;
#(
    parameter int          ITER = 4,
    parameter logic [31:0] SEED = 32'h3FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        div_start,
    output logic [31:0] div_n1,
    output logic [31:0] div_n2,
    input  logic        div_done,
    input  logic [31:0] div_result,
    output logic        add_start,
    output logic [31:0] add_n1,
    output logic [31:0] add_n2,
    output logic        add_sel,
    input  logic        add_done,
    input  logic [31:0] add_result
);

    localparam logic [3:0] ITER_L = 4'(ITER);

    state_t      state_r;
    logic [31:0] a_r;
    logic [31:0] m_r;
    logic [7:0]  half_r;
    logic [31:0] x_r;
    logic [31:0] s_r;
    logic [3:0]  k_r;

    logic        is_zero_s;
    logic        is_inf_s;
    logic        is_nan_s;
    logic        is_snan_s;
    logic        is_neg_s;

    logic [8:0]  e_s;
    logic [7:0]  half_s;
    logic [31:0] m_s;
    logic [31:0] x_next_s;

    logic        special_s;
    logic [31:0] spec_result_s;
    logic        spec_invalid_s;

    assign add_sel = 1'b0;

    fp_classify u_classify (
        .x       (a_r),
        .is_zero (is_zero_s),
        .is_inf  (is_inf_s),
        .is_nan  (is_nan_s),
        .is_snan (is_snan_s),
        .is_neg  (is_neg_s)
    );

    // Unbiased exponent; floor(e/2) is simply e[8:1] of the 9-bit two's complement value.
    assign e_s    = {1'b0, a_r[30:23]} - {1'b0, EXP_BIAS};
    assign half_s = e_s[8:1];
    // Odd exponents are folded into the mantissa so m lies in [1,4).
    assign m_s    = {1'b0, EXP_BIAS + {7'd0, e_s[0]}, a_r[22:0]};

    assign x_next_s = fp_halve(s_r);

    // Special-operand result selection for the latched operand.
    always_comb begin
        special_s      = 1'b1;
        spec_result_s  = 32'd0;
        spec_invalid_s = 1'b0;
        if (is_zero_s) begin
            spec_result_s = {a_r[31], 31'd0};
        end else if (is_nan_s) begin
            spec_result_s  = QNAN;
            spec_invalid_s = is_snan_s;
        end else if (is_neg_s) begin
            spec_result_s  = QNAN;
            spec_invalid_s = 1'b1;
        end else if (is_inf_s) begin
            spec_result_s = PINF;
        end else begin
            special_s = 1'b0;
        end
    end

    // Sequencer FSM with all handshake, operand and result outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            a_r       <= 32'd0;
            m_r       <= 32'd0;
            half_r    <= 8'd0;
            x_r       <= 32'd0;
            s_r       <= 32'd0;
            k_r       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            invalid   <= 1'b0;
            div_start <= 1'b0;
            div_n1    <= 32'd0;
            div_n2    <= 32'd0;
            add_start <= 1'b0;
            add_n1    <= 32'd0;
            add_n2    <= 32'd0;
        end else begin
            div_start <= 1'b0;
            add_start <= 1'b0;
            done      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        busy    <= 1'b1;
                        state_r <= PREP;
                    end
                end
                PREP: begin
                    if (special_s) begin
                        result  <= spec_result_s;
                        invalid <= spec_invalid_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        m_r       <= m_s;
                        half_r    <= half_s;
                        x_r       <= SEED;
                        k_r       <= 4'd0;
                        div_n1    <= m_s;
                        div_n2    <= SEED;
                        div_start <= 1'b1;
                        state_r   <= DIV_REQ;
                    end
                end
                DIV_REQ: begin
                    state_r <= DIV_WAIT;
                end
                DIV_WAIT: begin
                    if (div_done) begin
                        add_n1    <= div_result;
                        add_n2    <= x_r;
                        add_start <= 1'b1;
                        state_r   <= ADD_REQ;
                    end
                end
                ADD_REQ: begin
                    state_r <= ADD_WAIT;
                end
                ADD_WAIT: begin
                    if (add_done) begin
                        s_r     <= add_result;
                        state_r <= HALVE;
                    end
                end
                HALVE: begin
                    x_r <= x_next_s;
                    k_r <= k_r + 4'd1;
                    if ((k_r + 4'd1) == ITER_L) begin
                        state_r <= PACK;
                    end else begin
                        div_n1    <= m_r;
                        div_n2    <= x_next_s;
                        div_start <= 1'b1;
                        state_r   <= DIV_REQ;
                    end
                end
                PACK: begin
                    result  <= fp_scale(x_r, half_r);
                    invalid <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= DONE;
                end
                DONE: begin
                    // busy is already low here, so a new request is taken immediately.
                    if (start) begin
                        a_r     <= a;
                        busy    <= 1'b1;
                        state_r <= PREP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_nr_sequencer.sv
// Scoreboard bench for fsqrt_nr_sequencer: emulated divider/adder units,
// a real-arithmetic sqrt reference, and a monitor checking every done.
module tb_fsqrt_nr_sequencer;

    localparam int ITER = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a = 32'd0;
    logic        busy, done, invalid;
    logic [31:0] result;
    logic        div_start, add_start, add_sel;
    logic [31:0] div_n1, div_n2, add_n1, add_n2;
    logic        div_done = 1'b0;
    logic [31:0] div_result = 32'd0;
    logic        add_done = 1'b0;
    logic [31:0] add_result = 32'd0;

    fsqrt_nr_sequencer #(.ITER(ITER), .SEED(32'h3FC0_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .invalid    (invalid),
        .div_start  (div_start),
        .div_n1     (div_n1),
        .div_n2     (div_n2),
        .div_done   (div_done),
        .div_result (div_result),
        .add_start  (add_start),
        .add_n1     (add_n1),
        .add_n2     (add_n2),
        .add_sel    (add_sel),
        .add_done   (add_done),
        .add_result (add_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int ld = 1;
    int la = 1;
    int rst_epoch = 0;
    int div_cnt = 0;
    int add_cnt = 0;
    bit div_busy = 1'b0;
    bit add_busy = 1'b0;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        int          tol;
        int          lat;
        int          acc;
        int          nreq;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], {3'd0, f[30:23]} + 11'd896, f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round a double to the nearest single (ties to even); operands stay in normal range.
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [30:0] mag;
        logic [28:0] rem;
        d   = $realtobits(r);
        mag = {8'(d[62:52] - 11'd896), d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
        return {d[63], mag};
    endfunction

    function automatic void model(input logic [31:0] av, output logic [31:0] res,
                                  output logic inv, output bit sp);
        sp  = 1'b1;
        inv = 1'b0;
        if (av[30:23] == 8'd0) begin
            res = {av[31], 31'd0};
        end else if (av[30:23] == 8'hFF && av[22:0] != 23'd0) begin
            res = 32'h7FC0_0000;
            inv = ~av[22];
        end else if (av[31]) begin
            res = 32'h7FC0_0000;
            inv = 1'b1;
        end else if (av[30:23] == 8'hFF) begin
            res = 32'h7F80_0000;
        end else begin
            sp  = 1'b0;
            res = r2f($sqrt(f2r(av)));
        end
    endfunction

    // Emulated divider: answers ld cycles after a request; operands must hold meanwhile.
    logic [31:0] dn1, dn2;
    int dep, dlat;
    initial begin : div_unit
        forever begin
            @(posedge clk); #1;
            div_done = 1'b0;
            if (div_start) begin
                div_cnt++;
                dn1 = div_n1; dn2 = div_n2; dep = rst_epoch; dlat = ld;
                div_busy = 1'b1;
                for (int i = 0; i < dlat; i++) begin
                    @(posedge clk); #1;
                    if (dep == rst_epoch && rst) begin
                        check("div_n1_stable", div_n1, dn1);
                        check("div_n2_stable", div_n2, dn2);
                    end
                end
                div_result = r2f(f2r(dn1) / f2r(dn2));
                div_done   = 1'b1;
                div_busy   = 1'b0;
            end
        end
    end

    // Emulated adder: answers la cycles after a request.
    logic [31:0] an1, an2;
    int aep, alat;
    initial begin : add_unit
        forever begin
            @(posedge clk); #1;
            add_done = 1'b0;
            if (add_start) begin
                add_cnt++;
                an1 = add_n1; an2 = add_n2; aep = rst_epoch; alat = la;
                add_busy = 1'b1;
                for (int i = 0; i < alat; i++) begin
                    @(posedge clk); #1;
                    if (aep == rst_epoch && rst) begin
                        check("add_n1_stable", add_n1, an1);
                        check("add_n2_stable", add_n2, an2);
                    end
                end
                add_result = r2f(f2r(an1) + f2r(an2));
                add_done   = 1'b1;
                add_busy   = 1'b0;
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    exp_t me;
    int base_d = 0;
    int base_a = 0;
    int diff;
    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                sb.delete();
                base_d = div_cnt;
                base_a = add_cnt;
            end else if (done) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done=1 with result %h, expected no done", result);
                end else begin
                    me = sb.pop_front();
                    check("busy_at_done", {31'd0, busy}, 32'd0);
                    check("invalid", {31'd0, invalid}, {31'd0, me.inv});
                    diff = (result > me.res) ? int'(result - me.res) : int'(me.res - result);
                    n_cmp++;
                    if (diff > me.tol) begin
                        n_bad++;
                        $display("FAIL result: got %h expected %h (tol %0d ulp)", result, me.res, me.tol);
                    end
                    check("latency", cyc - me.acc, me.lat);
                    check("div_requests", div_cnt - base_d, me.nreq);
                    check("add_requests", add_cnt - base_a, me.nreq);
                    check("add_sel", {31'd0, add_sel}, 32'd0);
                end
                base_d = div_cnt;
                base_a = add_cnt;
            end
        end
    end

    task automatic issue(input logic [31:0] av, input int tol, input int nld, input int nla);
        logic [31:0] r;
        logic        inv;
        bit          sp;
        int          budget;
        exp_t        e;
        budget = 0;
        while (busy !== 1'b0 && budget < 500) begin
            @(posedge clk); #1;
            budget++;
        end
        if (budget >= 500) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: got busy=%b expected 0 within 500 cycles", busy);
            return;
        end
        ld = nld; la = nla;
        start = 1'b1; a = av;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom;
        check("accepted_busy", {31'd0, busy}, 32'd1);
        model(av, r, inv, sp);
        e.res  = r;
        e.inv  = inv;
        e.tol  = tol;
        e.lat  = sp ? 1 : 2 + ITER * (nld + nla + 3);
        e.acc  = cyc;
        e.nreq = sp ? 0 : ITER;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {27'd0, busy, done, invalid, div_start, add_start}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_div_ops"}, div_n1 | div_n2, 32'd0);
        check({tag, "_add_ops"}, add_n1 | add_n2, 32'd0);
    endtask

    logic [31:0] rv;
    int budget;
    initial begin : stim
        #2 rst = 1'b0;
        rst_epoch++;
        #4;
        check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Perfect square, 1-cycle units: 22-cycle latency, 4 requests of each kind.
        issue(32'h4080_0000, 0, 1, 1);
        // Odd exponent (sqrt 2) and negative exponent (0.25).
        issue(32'h4000_0000, 1, 1, 1);
        issue(32'h3E80_0000, 0, 1, 1);
        // Special operands, back to back.
        issue(32'hC080_0000, 0, 1, 1);
        issue(32'h7F80_0001, 0, 1, 1);
        issue(32'h8000_0000, 0, 1, 1);
        // Slow divider plus a start pulse while busy that must be ignored.
        issue(32'h4080_0000, 0, 7, 1);
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b1; a = 32'h4110_0000;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ignores_start", {31'd0, busy}, 32'd1);

        // Reset during DIV_WAIT; the late div_done must not revive the operation.
        issue(32'h4080_0000, 0, 12, 1);
        budget = 0;
        while (!div_busy && budget < 50) begin @(posedge clk); #1; budget++; end
        check("reached_div_wait", {31'd0, div_busy}, 32'd1);
        repeat (3) begin @(posedge clk); #1; end
        #3 rst = 1'b0;
        rst_epoch++;
        #2;
        check_reset_outputs("midop_reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        budget = 0;
        while (div_busy && budget < 50) begin @(posedge clk); #1; budget++; end
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("after_stale_done");
        issue(32'h4110_0000, 0, 1, 1);

        // Randomized operands and unit latencies.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0: rv = {1'($urandom), 8'd0, 23'($urandom)};
                1: rv = 32'h7F80_0000;
                2: rv = {1'($urandom), 8'hFF, 1'b1, 22'($urandom)};
                3: rv = {1'($urandom), 8'hFF, 1'b0, 22'($urandom_range(1, 4194303))};
                4: rv = {1'b1, 8'($urandom_range(1, 254)), 23'($urandom)};
                5: rv = 32'hFF80_0000;
                default: rv = {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
            endcase
            issue(rv, 1, $urandom_range(1, 4), $urandom_range(1, 4));
        end

        budget = 0;
        while (sb.size() != 0 && budget < 3000) begin @(posedge clk); #1; budget++; end
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fsqrt_nr_sequencer.md
Name: fsqrt_nr_sequencer

Overview:
- Multi-cycle IEEE-754 single-precision square root.
- Computes the result by Newton-Raphson on the mantissa: x(k+1) = 0.5*(x(k) + m/x(k)).
- Does not contain its own divider or adder. It is the initiator side of the FPU operator start/done handshake, driving one shared external divider and one shared external adder.
- Sits between the FP execute stage (start/done requester) and the shared FPU arithmetic units, replacing the fully combinational three-divider sqrt datapath.

Parameters:
- ITER, 4, number of Newton-Raphson iterations (1..7).
- SEED, 32'h3FC00000, initial estimate x0 = 1.5.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; a is sampled when start=1 and busy=0.
- a  in  32  operand.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; result/invalid valid that cycle and held afterwards.
- result  out  32  square root.
- invalid  out  1  set for negative non-zero operand or signalling NaN.
- div_start  out  1  one-cycle request to the divider.
- div_n1, div_n2  out  32 each  dividend and divisor.
- div_done  in  1  divider completion pulse.
- div_result  in  32  quotient, sampled on div_done.
- add_start  out  1  one-cycle request to the adder.
- add_n1, add_n2  out  32 each  addends.
- add_sel  out  1  tied to 0 (add).
- add_done  in  1  adder completion pulse.
- add_result  in  32  sum, sampled on add_done.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. busy, done, invalid, div_start and add_start are 0. result and all operand outputs are 0.
- Classification at accept (E = a[30:23]):
  - E=0 (zero or denormal): result = {a[31],31'b0}; denormals are flushed.
  - +inf: result = 7F800000.
  - NaN: result = 7FC00000; invalid = 1 only for sNaN.
  - Negative non-zero: result = 7FC00000, invalid = 1.
  - Special path: state DONE on the next edge, so done asserts in cycle T+1 after the accept edge T. No div_start or add_start is issued.
- Normal path (state PREP, 1 cycle):
  - e = E-127 (signed 9-bit). half = e>>>1 (arithmetic shift, floor).
  - m = {0, 127+e[0], a[22:0]}, so m lies in [1,4). This folds odd exponents into the mantissa; no sqrt2 correction is needed.
  - x = SEED. Iteration counter k = 0.
- Iteration loop:
  - DIV_REQ: div_start=1 for exactly 1 cycle; div_n1=m, div_n2=x.
  - DIV_WAIT: wait for div_done; latch q.
  - ADD_REQ: add_start=1 for 1 cycle; add_n1=q, add_n2=x.
  - ADD_WAIT: wait for add_done; latch s.
  - HALVE: x = {s[31], s[30:23]-1, s[22:0]}; k++. If k==ITER go to PACK, else go to DIV_REQ.
- Operand outputs are registers. They stay stable from the request cycle until the matching done is observed.
- PACK: result = {0, x[30:23]+half[7:0], x[22:0]} (8-bit modular add; no overflow is possible for finite input).
- DONE: done=1 for 1 cycle, busy=0, return to IDLE.
- Latency (normal): 2 + ITER*(Ld+La+3) cycles from the accept edge to done. Ld/La are the cycles from request to done pulse, minimum 1. With ITER=4 and Ld=La=1 this is 22 cycles.
- start while busy: ignored; a is not resampled.
- start in the same cycle as done: accepted, because busy is already 0 that cycle.
- div_done/add_done outside the matching WAIT state: ignored. Both arriving together: only the one matching the state is used.
- Reset mid-operation: immediate return to IDLE. A stale done arriving after reset is ignored. No done pulse is generated for the aborted operation.
- invalid is updated only at done and held with result.

Decomposition:
- Package fpu_pkg holds:
  - state encoding (IDLE, PREP, DIV_REQ, DIV_WAIT, ADD_REQ, ADD_WAIT, HALVE, PACK, DONE);
  - constants QNAN=7FC00000, PINF=7F800000, EXP_BIAS=127.
- One combinational sub-module, fp_classify: takes a 32-bit input and outputs is_zero, is_inf, is_nan, is_snan, is_neg. It is reusable by other sequenced FPU ops.

Test Plan:
- a=40800000 (4.0), units answering 1 cycle after request -> done 22 cycles after accept; result 40000000, invalid 0; exactly 4 div_start and 4 add_start pulses.
- a=40000000 (2.0), then a=3E800000 (0.25) -> result 3FB504F3 ±1 ulp, then 3F000000 exact; checks the odd- and negative-exponent paths.
- a=C0800000, then 7F800001, then 80000000 -> results 7FC00000 with invalid 1; 7FC00000 with invalid 1; 80000000 with invalid 0; each done at T+1; no unit requests.
- Divider holds div_done off for 7 cycles -> div_n1/div_n2 stable throughout; a start pulse during busy is ignored; result unchanged vs the 1-cycle case.
- rst low during DIV_WAIT, release, then a div_done pulse arrives -> outputs at reset values, no done; a new start with a=41100000 (9.0) yields 40400000.
